// File: rtl/input_port_controller.sv
// input_port_controller: flit FIFO plus IDLE/REQ/FWD packet controller for one router input port.
// Ports: clk/rst (async active-high); in_data/in_valid/in_ready link side; head_flit/decoded_request
// routing decoder loop; request/request_valid/grant switch allocator; out_data/out_valid/out_ready
// crossbar side; drop_error pulses when a flit arrives outside a packet and is discarded.
module input_port_controller #(
  parameter int N             = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int PhitPerFlit   = 2,
  parameter int REQUEST_WIDTH = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PhitPerFlit*DATA_WIDTH-1:0] in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [PhitPerFlit*DATA_WIDTH-1:0] head_flit,
  input  logic [REQUEST_WIDTH-1:0]          decoded_request,
  output logic [REQUEST_WIDTH-1:0]          request,
  output logic                              request_valid,
  input  logic                              grant,
  output logic [PhitPerFlit*DATA_WIDTH-1:0] out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              drop_error
);
  localparam int FLIT_W = PhitPerFlit * DATA_WIDTH;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  if (N < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("input_port_controller: N must be >= 2 and FIFO_DEPTH a power of two >= 2");
  end
  typedef enum logic [1:0] {IDLE, REQ, FWD} state_t;
  state_t                   state_q, state_d;
  logic [FLIT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [FLIT_W-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]            wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [REQUEST_WIDTH-1:0] req_q, req_d;
  logic [FLIT_W-1:0]        front;
  logic                     empty, push, pop, is_head, is_tail;
  assign front     = mem_q[rd_q];
  // type code 01 head, 00 body, 10 tail, 11 single: bit 0 marks a head, bit 1 a tail
  assign is_head   = front[FLIT_W-2];
  assign is_tail   = front[FLIT_W-1];
  assign empty     = cnt_q == '0;
  assign in_ready  = cnt_q != CW'(FIFO_DEPTH);
  assign push      = in_valid & in_ready;
  assign head_flit = front;
  assign out_data  = front;
  assign request   = req_q;
  always_comb begin
    request_valid = state_q != IDLE;
    out_valid     = (state_q == FWD) & ~empty;
    drop_error    = (state_q == IDLE) & ~empty & ~is_head;
    pop           = drop_error | (out_valid & out_ready);
  end
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      IDLE: if (!empty && is_head) begin
        state_d = REQ;
        req_d   = decoded_request;
      end
      REQ:     state_d = grant ? FWD : REQ;
      FWD:     state_d = (pop && is_tail) ? IDLE : FWD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = in_data;
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end
endmodule
